// File: rtl/sw16_rd.sv
// sw16_rd: 16-wide switch/button reader. It synchronizes each input, debounces it on a shared tick, and emits rise/fall/chg strobes.
// Define SW16_RD_EVLATCH_EN to add sticky per-bit event flags and irq. Without it, ev/irq are tied to 0.

module sw16_rd_bit #(
    parameter int STABLE_N = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s2,
    input  logic tick,
    output logic q,
    output logic rise,
    output logic fall,
    output logic acc
);
    logic [3:0] cnt;

    // acc marks the tick that completes qualification; the top ORs these into chg
    assign acc = (s2 != q) && tick && (cnt == 4'(STABLE_N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            q    <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (s2 == q) begin
                cnt <= '0;
            end else if (tick) begin
                if (acc) begin
                    q    <= s2;
                    cnt  <= '0;
                    rise <= s2;
                    fall <= ~s2;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end
        end
    end
endmodule

module sw16_rd #(
    parameter int TICK_DIV = 4,
    parameter int STABLE_N = 3,
    parameter int CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] sw,
    output logic [15:0] sw_q,
    output logic [15:0] rise,
    output logic [15:0] fall,
    output logic        chg,
    input  logic [15:0] ev_clr,
    output logic [15:0] ev,
    output logic        irq
);
    localparam int NUM_LANES = 16;

    logic [NUM_LANES-1:0] s1, s2, acc;
    logic [CNT_W-1:0]     pcnt;
    logic                 tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw;
            s2 <= s1;
        end
    end

    assign tick = en && (pcnt == CNT_W'(TICK_DIV - 1));

    // Holding the prescaler at 0 while disabled makes every resume start from a full tick period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    pcnt <= '0;
        else if (!en)  pcnt <= '0;
        else if (tick) pcnt <= '0;
        else           pcnt <= pcnt + CNT_W'(1);
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        sw16_rd_bit #(.STABLE_N(STABLE_N)) u_bit (
            .clk  (clk),
            .rst_n(rst_n),
            .s2   (s2[i]),
            .tick (tick),
            .q    (sw_q[i]),
            .rise (rise[i]),
            .fall (fall[i]),
            .acc  (acc[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chg <= 1'b0;
        else        chg <= |acc;
    end

`ifdef SW16_RD_EVLATCH_EN
    // A set arriving in the same cycle as its clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev  <= '0;
            irq <= 1'b0;
        end else begin
            ev  <= (ev & ~ev_clr) | rise | fall;
            irq <= |ev;
        end
    end
`else
    logic ev_clr_unused;
    assign ev_clr_unused = ^ev_clr;
    assign ev  = '0;
    assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_sw16_rd.sv
// Scoreboard bench for sw16_rd. Expected events are queued at stimulus time and matched against the strobes the DUT produces.
// The ev/irq expectations follow SW16_RD_EVLATCH_EN, so the same bench serves both builds.

module tb_sw16_rd;
    logic        clk = 1'b0;
    logic        rst_n, en, chg, irq;
    logic [15:0] sw, ev_clr, sw_q, rise, fall, ev;

    sw16_rd dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sw(sw), .sw_q(sw_q), .rise(rise),
        .fall(fall), .chg(chg), .ev_clr(ev_clr), .ev(ev), .irq(irq)
    );

    always #5 clk = ~clk;

`ifdef SW16_RD_EVLATCH_EN
    localparam logic [15:0] EV4  = 16'h0004;
    localparam logic        IRQ1 = 1'b1;
`else
    localparam logic [15:0] EV4  = 16'h0000;
    localparam logic        IRQ1 = 1'b0;
`endif

    typedef struct {
        logic [15:0] rise, fall, q;
        logic        chg;
        int          cyc;
    } obs_t;
    typedef struct {
        logic [15:0] rise, fall, q;
        int          t0, lo, hi;
    } exp_t;

    obs_t        obs[$];
    exp_t        exp_q[$];
    obs_t        o;
    exp_t        e;
    logic [15:0] mq;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (((|(rise | fall)) || chg) === 1'b1)
            obs.push_back('{rise, fall, sw_q, chg, cyc});

`ifndef SW16_RD_EVLATCH_EN
    logic ev_nz = 1'b0;
    always @(negedge clk) if (ev !== 16'h0 || irq !== 1'b0) ev_nz = 1'b1;
`endif

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, need test done");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference debounce model: the accepted value jumps from mq to v
    task automatic push_exp(input logic [15:0] v, input int lo, input int hi);
        exp_q.push_back('{v & ~mq, ~v & mq, v, cyc, lo, hi});
        mq = v;
    endtask

    task automatic wait_obs(input int n, input int budget);
        int k = 0;
        while (obs.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b1; sw = 16'hFFFF; ev_clr = 16'h0; mq = 16'h0;
        repeat (20) @(negedge clk);
        total++;
        if ({sw_q, rise, fall, chg, ev, irq} !== 66'h0) begin
            bad++;
            $display("FAIL reset_state: sw_q=%h rise=%h fall=%h chg=%b ev=%h irq=%b, need all 0",
                     sw_q, rise, fall, chg, ev, irq);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        push_exp(16'hFFFF, 11, 14);
        e = exp_q.pop_front();
        wait_obs(1, 40);
        total++;
        if (obs.size() == 0) begin
            bad++; $display("FAIL reset_release: no event, need rise=%h", e.rise);
        end else begin
            o = obs.pop_front();
            total++;
            if ({o.rise, o.fall, o.q, o.chg} !== {e.rise, e.fall, e.q, 1'b1}) begin
                bad++;
                $display("FAIL reset_release: r=%h f=%h q=%h chg=%b, need r=%h f=%h q=%h chg=1",
                         o.rise, o.fall, o.q, o.chg, e.rise, e.fall, e.q);
            end
            total++;
            if (o.cyc - e.t0 < e.lo || o.cyc - e.t0 > e.hi) begin
                bad++; $display("FAIL reset_latency: %0d clks, need %0d..%0d", o.cyc - e.t0, e.lo, e.hi);
            end
        end
        step(4);
        total++;
        if (obs.size() != 0) begin
            bad++; $display("FAIL reset_single: %0d extra strobes, need 0", obs.size()); obs.delete();
        end
    endtask

    task automatic test_edges;
        logic [15:0] seq [2];
        seq[0] = 16'h0000;
        seq[1] = 16'h0001;
        for (int i = 0; i < 2; i++) begin
            step(1);
            sw = seq[i];
            push_exp(seq[i], 11, 14);
            e = exp_q.pop_front();
            wait_obs(1, 40);
            total++;
            if (obs.size() == 0) begin
                bad++; $display("FAIL edge%0d: no event, need r=%h f=%h", i, e.rise, e.fall);
            end else begin
                o = obs.pop_front();
                total++;
                if ({o.rise, o.fall, o.q, o.chg} !== {e.rise, e.fall, e.q, 1'b1}) begin
                    bad++;
                    $display("FAIL edge%0d: r=%h f=%h q=%h chg=%b, need r=%h f=%h q=%h chg=1",
                             i, o.rise, o.fall, o.q, o.chg, e.rise, e.fall, e.q);
                end
                total++;
                if (o.cyc - e.t0 < e.lo || o.cyc - e.t0 > e.hi) begin
                    bad++; $display("FAIL edge%0d_latency: %0d clks, need %0d..%0d", i, o.cyc - e.t0, e.lo, e.hi);
                end
            end
            step(4);
            total++;
            if (obs.size() != 0) begin
                bad++; $display("FAIL edge%0d_single: %0d extra strobes, need 0", i, obs.size()); obs.delete();
            end
        end
    endtask

    task automatic test_glitch;
        step(1);
        sw[5] = 1'b1;
        step(6);
        sw[5] = 1'b0;
        step(30);
        total++;
        if (obs.size() != 0 || sw_q !== mq) begin
            bad++; $display("FAIL glitch: %0d strobes sw_q=%h, need 0 strobes sw_q=%h", obs.size(), sw_q, mq);
            obs.delete();
        end
        for (int i = 0; i < 6; i++) begin
            sw[5] = (i % 2 == 0);
            step(3);
        end
        sw[5] = 1'b1;
        push_exp(sw, 11, 14);
        e = exp_q.pop_front();
        wait_obs(1, 40);
        step(6);
        total++;
        if (obs.size() != 1) begin
            bad++; $display("FAIL bounce_count: %0d strobes, need 1", obs.size());
        end
        if (obs.size() > 0) begin
            o = obs.pop_front();
            total++;
            if ({o.rise, o.fall, o.q} !== {e.rise, e.fall, e.q} ||
                o.cyc - e.t0 < e.lo || o.cyc - e.t0 > e.hi) begin
                bad++;
                $display("FAIL bounce_rise: r=%h f=%h q=%h lat=%0d, need r=%h f=%h q=%h lat %0d..%0d",
                         o.rise, o.fall, o.q, o.cyc - e.t0, e.rise, e.fall, e.q, e.lo, e.hi);
            end
            obs.delete();
        end
    endtask

    task automatic test_enable_freeze;
        logic moved = 1'b0;
        step(1);
        sw[3] = 1'b1;
        step(6);
        en = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (sw_q[3] !== 1'b0) moved = 1'b1;
        end
        total++;
        if (moved !== 1'b0 || obs.size() != 0) begin
            bad++; $display("FAIL freeze_hold: moved=%b strobes=%0d, need 0/0", moved, obs.size());
            obs.delete();
        end
        en = 1'b1;
        push_exp(sw, 1, 14);
        e = exp_q.pop_front();
        wait_obs(1, 40);
        total++;
        if (obs.size() == 0) begin
            bad++; $display("FAIL freeze_resume: no event, need r=%h", e.rise);
        end else begin
            o = obs.pop_front();
            total++;
            if ({o.rise, o.fall, o.q} !== {e.rise, e.fall, e.q} ||
                o.cyc - e.t0 < e.lo || o.cyc - e.t0 > e.hi) begin
                bad++;
                $display("FAIL freeze_resume: r=%h q=%h lat=%0d, need r=%h q=%h lat %0d..%0d",
                         o.rise, o.q, o.cyc - e.t0, e.rise, e.q, e.lo, e.hi);
            end
        end
    endtask

    task automatic test_multi_bit;
        logic [15:0] seq [2];
        seq[0] = 16'h0000;
        seq[1] = 16'hA5A5;
        for (int i = 0; i < 2; i++) begin
            step(2);
            sw = seq[i];
            push_exp(seq[i], 11, 14);
            e = exp_q.pop_front();
            wait_obs(1, 40);
            step(4);
            total++;
            if (obs.size() != 1) begin
                bad++; $display("FAIL multi%0d_count: %0d strobe cycles, need 1", i, obs.size());
            end
            if (obs.size() > 0) begin
                o = obs.pop_front();
                total++;
                if ({o.rise, o.fall, o.q, o.chg} !== {e.rise, e.fall, e.q, 1'b1}) begin
                    bad++;
                    $display("FAIL multi%0d: r=%h f=%h q=%h chg=%b, need r=%h f=%h q=%h chg=1",
                             i, o.rise, o.fall, o.q, o.chg, e.rise, e.fall, e.q);
                end
                obs.delete();
            end
        end
    endtask

    task automatic test_evlatch;
        int k;
        step(1);
        ev_clr = 16'hFFFF; step(1); ev_clr = 16'h0;
        total++;
        if (ev !== 16'h0) begin bad++; $display("FAIL ev_clrall: ev=%h, need 0000", ev); end
        step(1);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL irq_clrall: irq=%b, need 0", irq); end

        sw = 16'hA5A1; push_exp(sw, 11, 14);
        wait_obs(1, 40);
        step(2);
        total++;
        if (ev !== EV4 || irq !== IRQ1) begin
            bad++; $display("FAIL ev_fall: ev=%h irq=%b, need %h/%b", ev, irq, EV4, IRQ1);
        end
        ev_clr = 16'h0004; step(1); ev_clr = 16'h0;
        total++;
        if (ev !== 16'h0) begin bad++; $display("FAIL ev_clr2: ev=%h, need 0000", ev); end
        step(1);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL irq_clr2: irq=%b, need 0", irq); end

        sw = 16'hA5A5; push_exp(sw, 11, 14);
        k = 0;
        do begin @(negedge clk); k++; end while (rise[2] !== 1'b1 && k < 20);
        @(negedge clk);
        total++;
        if (ev !== EV4) begin bad++; $display("FAIL ev_set: ev=%h, need %h", ev, EV4); end
        @(negedge clk);
        total++;
        if (irq !== IRQ1) begin bad++; $display("FAIL irq_set: irq=%b, need %b", irq, IRQ1); end

        step(1);
        sw = 16'hA5A1; push_exp(sw, 11, 14);
        wait_obs(3, 40);
        step(2);
        ev_clr = 16'h0004; step(1); ev_clr = 16'h0;
        sw = 16'hA5A5; push_exp(sw, 11, 14);
        k = 0;
        do begin @(negedge clk); k++; end while (rise[2] !== 1'b1 && k < 20);
        ev_clr = 16'h0004;
        @(posedge clk); #1;
        ev_clr = 16'h0;
        total++;
        if (ev !== EV4) begin bad++; $display("FAIL ev_setwins: ev=%h, need %h", ev, EV4); end
        step(4);
`ifndef SW16_RD_EVLATCH_EN
        total++;
        if (ev_nz !== 1'b0) begin bad++; $display("FAIL ev_tied: ev/irq seen nonzero, need 0"); end
`endif
        total++;
        if (obs.size() != exp_q.size()) begin
            bad++; $display("FAIL ev_events: %0d strobes, need %0d", obs.size(), exp_q.size());
        end
        while (obs.size() > 0 && exp_q.size() > 0) begin
            o = obs.pop_front();
            e = exp_q.pop_front();
            total++;
            if ({o.rise, o.fall, o.q} !== {e.rise, e.fall, e.q}) begin
                bad++; $display("FAIL ev_event: r=%h f=%h q=%h, need r=%h f=%h q=%h",
                                o.rise, o.fall, o.q, e.rise, e.fall, e.q);
            end
        end
    endtask

    initial begin
        test_reset;
        test_edges;
        test_glitch;
        test_enable_freeze;
        test_multi_bit;
        test_evlatch;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
